cache_controller: RTL and testbench

Control FSM for the cache; drives the `controller` modport of `cache_internal_if` while the cache datapath drives the `datapath` end. It accepts one CPU request at a time and performs the hit lookup. On a miss it sequences victim writeback and line fill over the hierarchical-memory (hmem) handshake. It emits per-access statistics strobes. It holds no tag or data storage; all storage and the line-word counter live in the datapath.

---
 rtl/cache_controller.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_cache_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - control FSM for the cache: hit lookup, victim writeback, line fill
//
// Purpose
//    Accepts one CPU request at a time and drives the control strobes of the
//    cache datapath (controller end of the cache-internal interface, flattened
//    to plain ports). A hit completes directly from LOOKUP. A miss optionally
//    writes the dirty victim back, fills the line word by word over the hmem
//    handshake, installs it and replays the lookup, which then hits.
//    The datapath owns all tag/data storage and the line-word counter.
//
// Optional feature
//    CACHE_CTRL_STATS_EN : when defined, count_hit/count_miss/count_read/
//    count_write pulse once per request at the first LOOKUP. When undefined
//    they are tied low and the replay flag is not built.
//
// Parameters
//    HMEM_WAIT_LIMIT : max consecutive WRITEBACK/FILL cycles without hmem_ack
//                      before aborting the request; 0 disables the watchdog.
//
// Ports
//    clk_i, reset_i                  clock, synchronous active-high reset
//    *_o (15 datapath strobes)       process_lru_counters, perform_write,
//                                    set/clear_selected_dirty_bit,
//                                    clear_selected_valid_bit,
//                                    set_hmem_block_address,
//                                    use_victim_tag_for_hmem_block_address,
//                                    reset_counter, decrement_counter,
//                                    miss_recovery_mode, finish_new_line_install,
//                                    count_hit, count_miss, count_read, count_write
//    counter_done_i                  datapath word counter is on the last word
//    valid_block_match_i             requested block is present
//    valid_dirty_bit_i               selected victim line is valid and dirty
//    req_valid_i, req_write_i        CPU request and its direction
//    req_ready_o, resp_valid_o       ready to accept / one-cycle completion pulse
//    hmem_req_valid_o                hmem word transfer requested
//    hmem_req_write_o                1 = writeback word, 0 = fill word
//    hmem_ack_i                      hmem accepted/returned the current word
//    hmem_timeout_o                  sticky watchdog error flag

module cache_controller #(
   parameter int HMEM_WAIT_LIMIT = 0
) (
   input  logic clk_i,
   input  logic reset_i,

   output logic process_lru_counters_o,
   output logic perform_write_o,
   output logic set_selected_dirty_bit_o,
   output logic clear_selected_dirty_bit_o,
   output logic clear_selected_valid_bit_o,
   output logic set_hmem_block_address_o,
   output logic use_victim_tag_for_hmem_block_address_o,
   output logic reset_counter_o,
   output logic decrement_counter_o,
   output logic miss_recovery_mode_o,
   output logic finish_new_line_install_o,
   output logic count_hit_o,
   output logic count_miss_o,
   output logic count_read_o,
   output logic count_write_o,
   input  logic counter_done_i,
   input  logic valid_block_match_i,
   input  logic valid_dirty_bit_i,

   input  logic req_valid_i,
   input  logic req_write_i,
   output logic req_ready_o,
   output logic resp_valid_o,

   output logic hmem_req_valid_o,
   output logic hmem_req_write_o,
   input  logic hmem_ack_i,
   output logic hmem_timeout_o
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOOKUP    = 3'd1;
   localparam logic [2:0] S_WRITEBACK = 3'd2;
   localparam logic [2:0] S_FILL      = 3'd3;
   localparam logic [2:0] S_INSTALL   = 3'd4;

   // Wide enough to hold 0 .. HMEM_WAIT_LIMIT-1, never narrower than 1 bit.
   localparam int WCW = $clog2(HMEM_WAIT_LIMIT + 2);

   logic [2:0]     state_q, state_d;
   logic           active_q;
   logic           write_q, write_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           timeout_q, timeout_d;
   logic           accept;
   logic           wd_expire;

   // active_q holds req_ready low for the first cycle after reset so every
   // output reads 0 until one clean edge has passed with reset low.
   assign accept = (state_q == S_IDLE) && active_q && req_valid_i;

   // Expires in the cycle that would be the LIMIT-th consecutive ack-less
   // hmem cycle; the abort happens on the edge that ends that cycle.
   assign wd_expire = (HMEM_WAIT_LIMIT > 0) && !hmem_ack_i &&
                      (int'(wait_cnt_q) == HMEM_WAIT_LIMIT - 1);

`ifdef CACHE_CTRL_STATS_EN
   // Set by INSTALL so the replayed LOOKUP does not count the access twice.
   logic replay_q, replay_d;

   always_comb begin
      replay_d = replay_q;
      if (accept) begin
         replay_d = 1'b0;
      end else if (state_q == S_INSTALL) begin
         replay_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         replay_q <= 1'b0;
      end else begin
         replay_q <= replay_d;
      end
   end
`endif

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               write_d = req_write_i;
               state_d = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            if (valid_block_match_i) begin
               state_d = S_IDLE;
            end else begin
               wait_cnt_d = '0;
               state_d    = valid_dirty_bit_i ? S_WRITEBACK : S_FILL;
            end
         end

         S_WRITEBACK: begin
            if (hmem_ack_i) begin
               wait_cnt_d = '0;
               if (counter_done_i) begin
                  state_d = S_FILL;
               end
            end else if (wd_expire) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end

         S_FILL: begin
            if (hmem_ack_i) begin
               wait_cnt_d = '0;
               if (counter_done_i) begin
                  state_d = S_INSTALL;
               end
            end else if (wd_expire) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end

         S_INSTALL: begin
            state_d = S_LOOKUP;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode: all strobes are combinational from state and inputs.
   always_comb begin
      process_lru_counters_o                  = 1'b0;
      perform_write_o                         = 1'b0;
      set_selected_dirty_bit_o                = 1'b0;
      clear_selected_dirty_bit_o              = 1'b0;
      clear_selected_valid_bit_o              = 1'b0;
      set_hmem_block_address_o                = 1'b0;
      use_victim_tag_for_hmem_block_address_o = 1'b0;
      reset_counter_o                         = 1'b0;
      decrement_counter_o                     = 1'b0;
      miss_recovery_mode_o                    = 1'b0;
      finish_new_line_install_o               = 1'b0;
      count_hit_o                             = 1'b0;
      count_miss_o                            = 1'b0;
      count_read_o                            = 1'b0;
      count_write_o                           = 1'b0;
      req_ready_o                             = 1'b0;
      resp_valid_o                            = 1'b0;
      hmem_req_valid_o                        = 1'b0;
      hmem_req_write_o                        = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready_o = active_q;
         end

         S_LOOKUP: begin
            if (valid_block_match_i) begin
               process_lru_counters_o = 1'b1;
               resp_valid_o           = 1'b1;
               if (write_q) begin
                  perform_write_o          = 1'b1;
                  set_selected_dirty_bit_o = 1'b1;
               end
            end else begin
               set_hmem_block_address_o = 1'b1;
               reset_counter_o          = 1'b1;
               if (valid_dirty_bit_i) begin
                  use_victim_tag_for_hmem_block_address_o = 1'b1;
               end else begin
                  clear_selected_valid_bit_o = 1'b1;
               end
            end
`ifdef CACHE_CTRL_STATS_EN
            if (!replay_q) begin
               count_hit_o   = valid_block_match_i;
               count_miss_o  = !valid_block_match_i;
               count_read_o  = !write_q;
               count_write_o = write_q;
            end
`endif
         end

         S_WRITEBACK: begin
            miss_recovery_mode_o = 1'b1;
            hmem_req_valid_o     = 1'b1;
            hmem_req_write_o     = 1'b1;
            if (hmem_ack_i) begin
               if (counter_done_i) begin
                  // Last victim word: retire the victim and point hmem at the
                  // requested block for the fill that follows.
                  clear_selected_dirty_bit_o = 1'b1;
                  clear_selected_valid_bit_o = 1'b1;
                  set_hmem_block_address_o   = 1'b1;
                  reset_counter_o            = 1'b1;
               end else begin
                  decrement_counter_o = 1'b1;
               end
            end
         end

         S_FILL: begin
            miss_recovery_mode_o = 1'b1;
            hmem_req_valid_o     = 1'b1;
            if (hmem_ack_i) begin
               perform_write_o     = 1'b1;
               decrement_counter_o = !counter_done_i;
            end
         end

         S_INSTALL: begin
            finish_new_line_install_o = 1'b1;
         end

         default: begin
         end
      endcase
   end

   assign hmem_timeout_o = timeout_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         active_q   <= 1'b0;
         write_q    <= 1'b0;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         active_q   <= 1'b1;
         write_q    <= write_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized self-checking bench for cache_controller
module tb_cache_controller;

   localparam int W     = 4;
   localparam int LIMIT = 8;
`ifdef CACHE_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, req_valid, req_write, hmem_ack;
   logic counter_done, valid_block_match, valid_dirty_bit;
   logic process_lru_counters, perform_write, set_selected_dirty_bit;
   logic clear_selected_dirty_bit, clear_selected_valid_bit, set_hmem_block_address;
   logic use_victim_tag, reset_counter, decrement_counter, miss_recovery_mode;
   logic finish_new_line_install, count_hit, count_miss, count_read, count_write;
   logic req_ready, resp_valid, hmem_req_valid, hmem_req_write, hmem_timeout;
   logic [19:0] all_out;

   assign all_out = {process_lru_counters, perform_write, set_selected_dirty_bit,
                     clear_selected_dirty_bit, clear_selected_valid_bit, set_hmem_block_address,
                     use_victim_tag, reset_counter, decrement_counter, miss_recovery_mode,
                     finish_new_line_install, count_hit, count_miss, count_read, count_write,
                     req_ready, resp_valid, hmem_req_valid, hmem_req_write, hmem_timeout};

   cache_controller #(.HMEM_WAIT_LIMIT(LIMIT)) dut (
      .clk_i                                   (clk),
      .reset_i                                 (reset),
      .process_lru_counters_o                  (process_lru_counters),
      .perform_write_o                         (perform_write),
      .set_selected_dirty_bit_o                (set_selected_dirty_bit),
      .clear_selected_dirty_bit_o              (clear_selected_dirty_bit),
      .clear_selected_valid_bit_o              (clear_selected_valid_bit),
      .set_hmem_block_address_o                (set_hmem_block_address),
      .use_victim_tag_for_hmem_block_address_o (use_victim_tag),
      .reset_counter_o                         (reset_counter),
      .decrement_counter_o                     (decrement_counter),
      .miss_recovery_mode_o                    (miss_recovery_mode),
      .finish_new_line_install_o               (finish_new_line_install),
      .count_hit_o                             (count_hit),
      .count_miss_o                            (count_miss),
      .count_read_o                            (count_read),
      .count_write_o                           (count_write),
      .counter_done_i                          (counter_done),
      .valid_block_match_i                     (valid_block_match),
      .valid_dirty_bit_i                       (valid_dirty_bit),
      .req_valid_i                             (req_valid),
      .req_write_i                             (req_write),
      .req_ready_o                             (req_ready),
      .resp_valid_o                            (resp_valid),
      .hmem_req_valid_o                        (hmem_req_valid),
      .hmem_req_write_o                        (hmem_req_write),
      .hmem_ack_i                              (hmem_ack),
      .hmem_timeout_o                          (hmem_timeout)
   );

   // Single-line datapath stand-in: one line with valid/dirty/tag and a word counter.
   logic       line_valid    = 1'b0;
   logic       line_dirty    = 1'b0;
   logic [1:0] line_tag      = 2'd0;
   logic [1:0] cur_tag       = 2'd0;
   logic       dp_invalidate = 1'b0;
   int         cnt           = W - 1;

   assign valid_block_match = line_valid && (line_tag == cur_tag);
   assign valid_dirty_bit   = line_valid && line_dirty;
   assign counter_done      = (cnt == 0);

   always @(posedge clk) begin
      if (reset_counter)          cnt <= W - 1;
      else if (decrement_counter) cnt <= cnt - 1;
      if (dp_invalidate || clear_selected_valid_bit) line_valid <= 1'b0;
      if (set_selected_dirty_bit)   line_dirty <= 1'b1;
      if (clear_selected_dirty_bit) line_dirty <= 1'b0;
      if (finish_new_line_install) begin
         line_valid <= 1'b1;
         line_tag   <= cur_tag;
         line_dirty <= 1'b0;
      end
   end

   int vectors     = 0;
   int miscompares = 0;
   bit exp_timeout = 1'b0;
   int ack_zeros   = 0;
   bit ack_ph      = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // mode 0: ack always, 1: random (never more than 4 zeros in a row),
   // 2: every other cycle, 3: never
   task automatic drive_ack(input int mode);
      case (mode)
         0: hmem_ack = 1'b1;
         1: hmem_ack = (ack_zeros >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
         2: begin ack_ph = !ack_ph; hmem_ack = ack_ph; end
         default: hmem_ack = 1'b0;
      endcase
      ack_zeros = hmem_ack ? 0 : ack_zeros + 1;
   endtask

   task automatic invalidate_line();
      dp_invalidate = 1'b1;
      @(posedge clk); #1;
      dp_invalidate = 1'b0;
   endtask

   // Entered and left at posedge+1 with the controller idle.
   task automatic run_req(input bit wr, input logic [1:0] tag, input int mode);
      bit hit, dirty, miss, tmo, old_dirty, done;
      int cyc, bound, lat;
      int n_resp = 0, n_lru = 0, n_pw = 0, n_sd = 0, n_addr = 0, n_rst = 0, n_dec = 0;
      int n_vic = 0, n_cv = 0, n_cd = 0, n_fin = 0, n_wb = 0, n_fill = 0, n_hreq = 0;
      int n_mrm = 0, n_hit = 0, n_miss = 0, n_rd = 0, n_wr = 0;
      tmo       = (mode == 3);
      hit       = line_valid && (line_tag == tag);
      dirty     = !hit && line_valid && line_dirty;
      miss      = !hit;
      old_dirty = line_dirty;
      done      = 1'b0;
      lat       = 0;
      bound     = tmo ? 30 : 200;

      check("ready_idle", req_ready, 1);
      cur_tag   = tag;
      req_valid = 1'b1;
      req_write = wr;
      @(posedge clk); #1;
      req_valid = tmo ? 1'b0 : 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      drive_ack(mode);

      for (cyc = 1; cyc <= bound && !done; cyc++) begin
         @(negedge clk);
         check("ready_busy", req_ready, tmo && n_hreq >= LIMIT);
         check("timeout_flag", hmem_timeout, exp_timeout || (tmo && n_hreq >= LIMIT));
         check("dec_rst_overlap", decrement_counter & reset_counter, 0);
         n_lru  += int'(process_lru_counters);
         n_pw   += int'(perform_write);
         n_sd   += int'(set_selected_dirty_bit);
         n_addr += int'(set_hmem_block_address);
         n_rst  += int'(reset_counter);
         n_dec  += int'(decrement_counter);
         n_vic  += int'(use_victim_tag);
         n_cv   += int'(clear_selected_valid_bit);
         n_cd   += int'(clear_selected_dirty_bit);
         n_fin  += int'(finish_new_line_install);
         n_mrm  += int'(miss_recovery_mode);
         n_hit  += int'(count_hit);
         n_miss += int'(count_miss);
         n_rd   += int'(count_read);
         n_wr   += int'(count_write);
         if (hmem_req_valid) n_hreq++;
         if (hmem_req_valid && hmem_ack) begin
            if (hmem_req_write) n_wb++;
            else                n_fill++;
         end
         if (clear_selected_dirty_bit) check("wb_last_ack", n_wb, W);
         if (resp_valid) begin
            done      = 1'b1;
            lat       = cyc;
            n_resp++;
            req_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (!tmo && !done) begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
         end
         drive_ack(mode);
      end

      if (tmo) begin
         check("tmo_hreq_cycles", n_hreq, LIMIT);
         check("tmo_resp", n_resp, 0);
         check("tmo_fill_words", n_fill, 0);
         check("tmo_install", n_fin, 0);
         check("tmo_set_addr", n_addr, 1);
         check("tmo_line_valid", line_valid, 0);
         exp_timeout = 1'b1;
      end else begin
         check("resp_seen", done, 1);
         check("resp_count", n_resp, 1);
         if (mode == 0) begin
            check("latency", lat, hit ? 1 : (dirty ? 2 * W + 3 : W + 3));
            check("recovery_cycles", n_mrm, hit ? 0 : (dirty ? 2 * W : W));
         end
         check("lru", n_lru, 1);
         check("perform_write", n_pw, (hit ? 0 : W) + int'(wr));
         check("set_dirty", n_sd, wr);
         check("set_addr", n_addr, hit ? 0 : (dirty ? 2 : 1));
         check("reset_counter", n_rst, hit ? 0 : (dirty ? 2 : 1));
         check("decrement", n_dec, hit ? 0 : (dirty ? 2 * (W - 1) : W - 1));
         check("victim_tag", n_vic, dirty);
         check("clr_valid", n_cv, miss);
         check("clr_dirty", n_cd, dirty);
         check("install", n_fin, miss);
         check("wb_words", n_wb, dirty ? W : 0);
         check("fill_words", n_fill, miss ? W : 0);
         check("line_valid", line_valid, 1);
         check("line_tag", line_tag, tag);
         check("line_dirty", line_dirty, wr || (hit && old_dirty));
      end
      check("count_hit", n_hit, STATS && hit);
      check("count_miss", n_miss, STATS && miss);
      check("count_read", n_rd, STATS && !wr);
      check("count_write", n_wr, STATS && wr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      reset     = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      hmem_ack  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_out, 0);
      reset     = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("ready_after_reset", req_ready, 1);
      @(posedge clk); #1;

      run_req(1'b0, 2'd1, 0);   // clean read miss, acks every cycle
      run_req(1'b0, 2'd1, 0);   // read hit
      run_req(1'b1, 2'd1, 0);   // write hit
      run_req(1'b0, 2'd2, 2);   // dirty miss, acks every other cycle
      run_req(1'b1, 2'd2, 0);   // write hit
      run_req(1'b0, 2'd3, 0);   // dirty miss, acks every cycle
      run_req(1'b1, 2'd0, 1);   // clean write miss, random acks

      for (int i = 0; i < 150; i++) begin
         run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 2));
      end

      invalidate_line();
      run_req(1'b0, 2'd1, 3);   // no ack ever: watchdog
      check("ready_after_timeout", req_ready, 1);

      // Reset pulsed in the second FILL cycle of a clean miss.
      invalidate_line();
      cur_tag   = 2'd2;
      req_valid = 1'b1;
      req_write = 1'b0;
      hmem_ack  = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && n < 2; c++) begin
         @(negedge clk);
         if (hmem_req_valid) n++;
      end
      check("reached_second_fill", n, 2);
      reset = 1'b1;
      @(negedge clk);
      check("mid_miss_reset_outputs", all_out, 0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_mid_reset", req_ready, 1);
      check("timeout_cleared", hmem_timeout, 0);
      exp_timeout = 1'b0;
      @(posedge clk); #1;
      run_req(1'b1, 2'd3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
